dp_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that drives the simple dual-port 1024x16 memory:

---
 rtl/dp_fifo_ctrl_pkg.sv | 8 +
 rtl/fifo_out_buf.sv | 53 +++++
 rtl/dp_fifo_ctrl.sv | 83 ++++++++
 tb/tb_dp_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller and the 1024x16 simple dual-port memory it drives.
package dp_fifo_ctrl_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 10;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry register FIFO that absorbs the memory read latency; entry 0 is the head.
module fifo_out_buf
   import dp_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic [1:0]        cnt
);

   logic [DATA_W-1:0] entry0;
   logic [DATA_W-1:0] entry1;

   always_ff @(posedge clk) begin
      if (reset) begin
         entry0 <= '0;
         entry1 <= '0;
         cnt    <= 2'd0;
      end else begin
         case ({capture, pop})
            2'b10: begin
               if (cnt == 2'd0) entry0 <= din;
               else             entry1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; the new word lands behind whatever remains.
               if (cnt == 2'd1) begin
                  entry0 <= din;
               end else begin
                  entry0 <= entry1;
                  entry1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = entry0;
   assign valid = (cnt != 2'd0);

endmodule

// File: rtl/dp_fifo_ctrl.sv
// FIFO controller for an external simple dual-port memory with a 1-cycle registered read,
// sustaining one word per clock through a 2-entry output buffer.
module dp_fifo_ctrl
   import dp_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_adr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [ADDR_W-1:0] mem_rd_adr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [ADDR_W+1:0] count
);

   // Both streams are strict valid/ready: a word moves on a cycle where valid and ready
   // are both high; valid never waits on ready, and data is held while valid & !ready.

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   mem_cnt;
   logic              inflight;
   logic [1:0]        ob_cnt;
   logic [2:0]        ob_pending;
   logic              push;
   logic              pop;
   logic              fetch;

   // mem_cnt never exceeds DEPTH, so its MSB alone marks a full memory.
   assign s_ready = !reset && !mem_cnt[ADDR_W];
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // Words that will occupy the output buffer next cycle if nothing new is fetched.
   assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign fetch      = (mem_cnt != '0) && (ob_pending < 3'd2);

   assign mem_wr_en   = push;
   assign mem_wr_adr  = wr_ptr;
   assign mem_wr_data = s_data;
   assign mem_rd_adr  = rd_ptr;

   assign count = {1'b0, mem_cnt}
                + {{(ADDR_W+1){1'b0}}, inflight}
                + {{ADDR_W{1'b0}}, ob_cnt};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + ADDR_W'(1);
         if (fetch) rd_ptr <= rd_ptr + ADDR_W'(1);
         inflight <= fetch;
         mem_cnt  <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(fetch);
      end
   end

   fifo_out_buf #(
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk     (clk),
      .reset   (reset),
      .capture (inflight),
      .din     (mem_rd_data),
      .pop     (pop),
      .dout    (m_data),
      .valid   (m_valid),
      .cnt     (ob_cnt)
   );

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// Bench for dp_fifo_ctrl with a registered-read dual-port memory model and a
// queue-based reference: a word is presentable 3 cycles after its push, in order.
module tb_dp_fifo_ctrl;
   import dp_fifo_ctrl_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int AW = ADDR_W_DEF;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_adr;
   logic [DW-1:0] mem_wr_data;
   logic [AW-1:0] mem_rd_adr;
   logic [DW-1:0] mem_rd_data;
   logic [AW+1:0] count;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   dp_fifo_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_adr  (mem_wr_adr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_adr  (mem_rd_adr),
      .mem_rd_data (mem_rd_data),
      .count       (count)
   );

   // Simple dual-port memory: registered read, old data on same-address collision.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_adr] <= mem_wr_data;
      mem_rd_data <= mem[mem_rd_adr];
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit expired, got running expected finished");
      $fatal(1);
   end

   // ---------------- scoreboard / model ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   int            stamp_q[$];
   int            cyc = 0;
   int            wr_cnt = 0;
   int            n_pushes = 0;
   int            n_pops = 0;
   int            first_valid_cyc = -1;
   logic          checking = 1'b0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [DW-1:0] last_pop = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic model_valid();
      return (exp_q.size() != 0) && (cyc >= stamp_q[0] + 3);
   endfunction

   // ---------------- driver ----------------
   // Inputs are driven by the caller just after a falling edge; this checks the
   // settled outputs, advances one clock, and updates the model.
   task automatic step();
      logic mv;
      logic do_push;
      logic do_pop;
      #1;
      mv = model_valid();
      if (checking) begin
         check("m_valid", {31'd0, m_valid}, {31'd0, mv});
         if (mv) check("m_data", {16'd0, m_data}, {16'd0, exp_q[0]});
         check("count", {20'd0, count}, exp_q.size());
         if (reset)                           check("s_ready_rst", {31'd0, s_ready}, 0);
         else if (exp_q.size() < DEPTH)       check("s_ready", {31'd0, s_ready}, 1);
         else if (exp_q.size() == DEPTH + 2)  check("s_ready_full", {31'd0, s_ready}, 0);
         if (prev_hold) check("m_data_hold", {16'd0, m_data}, {16'd0, prev_data});
         check("mem_wr_adr", {22'd0, mem_wr_adr}, wr_cnt % DEPTH);
         check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, s_valid & s_ready});
      end
      do_push = s_valid && s_ready && !reset;
      do_pop  = mv && m_ready;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_hold = mv && !m_ready && !reset;
      prev_data = m_data;
      @(posedge clk);
      cyc++;
      if (reset) begin
         exp_q.delete();
         stamp_q.delete();
         wr_cnt = 0;
      end else begin
         if (do_pop) begin
            last_pop = exp_q.pop_front();
            void'(stamp_q.pop_front());
            n_pops++;
         end
         if (do_push) begin
            exp_q.push_back(s_data);
            stamp_q.push_back(cyc - 1);
            wr_cnt++;
            n_pushes++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(input int limit);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < limit && exp_q.size() != 0; i++) step();
      repeat (3) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int pop_base;
      int push_cyc;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      @(negedge clk);
      checking = 1'b1;

      // 1: reset held for three clocks
      repeat (2) step();
      #1;
      check("t1_s_ready_rst", {31'd0, s_ready}, 0);
      check("t1_m_valid_rst", {31'd0, m_valid}, 0);
      check("t1_count_rst", {20'd0, count}, 0);
      reset = 1'b0;
      step();
      check("t1_s_ready_after", {31'd0, s_ready}, 1);

      // 2: single word latency
      first_valid_cyc = -1;
      pop_base = n_pops;
      push_cyc = cyc;
      s_valid  = 1'b1;
      s_data   = 16'hA5A5;
      m_ready  = 1'b1;
      step();
      s_valid = 1'b0;
      repeat (6) step();
      check("t2_latency", first_valid_cyc - push_cyc, 3);
      check("t2_data", {16'd0, last_pop}, 32'hA5A5);
      check("t2_pops", n_pops - pop_base, 1);
      check("t2_count", {20'd0, count}, 0);

      // 3: fill to DEPTH+2 under backpressure, then drain in order
      m_ready = 1'b0;
      base = n_pushes;
      for (int i = 0; i < 1200 && (n_pushes - base) < DEPTH + 2; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(n_pushes - base);
         step();
      end
      s_valid = 1'b0;
      repeat (3) step();
      #1;
      check("t3_accepted", n_pushes - base, DEPTH + 2);
      check("t3_count_full", {20'd0, count}, 1026);
      check("t3_s_ready_full", {31'd0, s_ready}, 0);
      pop_base = n_pops;
      drain(1200);
      check("t3_drained", n_pops - pop_base, 1026);
      check("t3_last_word", {16'd0, last_pop}, 1025);

      // 4: streaming at one word per clock, wrapping the pointers
      base = n_pushes;
      pop_base = 0;
      for (int i = 0; i < 3000; i++) begin
         s_valid = 1'b1;
         s_data  = DW'($urandom);
         m_ready = 1'b1;
         if (i == 10) pop_base = n_pops;
         step();
      end
      check("t4_pushes", n_pushes - base, 3000);
      check("t4_throughput", n_pops - pop_base, 2990);
      drain(20);

      // 5: random valid/ready on both sides
      base = n_pushes;
      for (int i = 0; i < 40000 && (n_pushes - base) < 10000; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = DW'($urandom);
         m_ready = 1'($urandom_range(0, 1));
         step();
      end
      check("t5_pushes", n_pushes - base, 10000);
      drain(2000);

      // 6: reset mid-stream discards contents
      m_ready = 1'b0;
      base = n_pushes;
      for (int i = 0; i < 700 && (n_pushes - base) < 500; i++) begin
         s_valid = 1'b1;
         s_data  = DW'($urandom);
         step();
      end
      s_valid = 1'b0;
      repeat (4) step();
      #1;
      check("t6_count_500", {20'd0, count}, 500);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("t6_count_rst", {20'd0, count}, 0);
      check("t6_m_valid_rst", {31'd0, m_valid}, 0);
      s_valid = 1'b1;
      s_data  = 16'h1234;
      step();
      pop_base = n_pops;
      drain(20);
      check("t6_first_word", {16'd0, last_pop}, 32'h1234);
      check("t6_pops", n_pops - pop_base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
